mips_program_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the MIPS core's instruction memory. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, writes them sequentially into instruction memory starting at word 0, and verifies an XOR checksum. It holds the core in reset until a complete, verified image is loaded, which replaces file-based preloading of the instruction bank in hardware builds.

---
 rtl/mips_program_loader.sv | 126 ++++++++++++
 tb/tb_mips_program_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_program_loader.sv
// Boot-time loader: turns a byte stream into big-endian instruction words written
// sequentially into instruction memory, verifies an XOR checksum, and holds the core until done.
module mips_program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_CPU,
  input  logic              rst_CPU,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  // Word count and index are one bit wider than 16 so a full 2**ADDR_W image never wraps.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [16:0]       count_q, count_d;
  logic [16:0]       word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        xor_q, xor_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              active, accept;
  logic [16:0]       hdr_n, word_next;

  assign active     = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  assign byte_ready = active & ~start;
  assign accept     = byte_valid & byte_ready;
  assign hdr_n      = {1'b0, count_q[7:0], byte_data};
  assign word_next  = word_q + 17'd1;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d    = state_q;
    count_d    = count_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    xor_d      = xor_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (start) begin
      state_d    = S_HDR_HI;
      xor_d      = 8'h00;
      byte_cnt_d = 2'd0;
    end else if (accept) begin
      unique case (state_q)
        S_HDR_HI: begin
          count_d = {9'd0, byte_data};
          state_d = S_HDR_LO;
        end
        S_HDR_LO: begin
          count_d = hdr_n;
          word_d  = 17'd0;
          if (hdr_n > CAP)        state_d = S_ERROR;
          else if (hdr_n == 17'd0) state_d = S_CHECK;
          else                    state_d = S_DATA;
        end
        S_DATA: begin
          xor_d      = xor_q ^ byte_data;
          shift_d    = {shift_q[15:0], byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = word_q[ADDR_W-1:0];
            wdata_d = {shift_q, byte_data};
            word_d  = word_next;
            if (word_next == count_q) state_d = S_CHECK;
          end
        end
        S_CHECK: state_d = (byte_data == xor_q) ? S_DONE : S_ERROR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      xor_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q    <= state_d;
      count_q    <= count_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      xor_q      <= xor_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign cpu_hold = (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERROR);

endmodule

// File: tb/tb_mips_program_loader.sv
// Scoreboard bench for mips_program_loader: expected memory writes are queued as bytes
// are sent and a monitor compares every im_we pulse; status outputs are checked directly.
module tb_mips_program_loader;

  localparam int ADDR_W = 8;

  logic              clk_CPU = 1'b0;
  logic              rst_CPU = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready, im_we, cpu_hold, done, error;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  int checks = 0;
  int failures = 0;
  int we_count = 0;
  logic [39:0] exp_q[$];

  mips_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_CPU(clk_CPU), .rst_CPU(rst_CPU), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk_CPU = ~clk_CPU;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk_CPU) begin
    if (im_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, im_addr, im_wdata}, 64'hDEAD);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {24'd0, im_addr, im_wdata}, {24'd0, e});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk_CPU);
      byte_valid = 1'b0;
    end
    @(negedge clk_CPU);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 16 && byte_ready !== 1'b1; k++) @(negedge clk_CPU);
    if (byte_ready !== 1'b1) begin
      check("ready_timeout", {63'd0, byte_ready}, 64'd1);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk_CPU);
    end
  endtask

  task automatic idle_bus();
    @(negedge clk_CPU);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk_CPU);
    start = 1'b1;
    @(posedge clk_CPU);
    #1 start = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w, input int gap);
    exp_q.push_back({a, w});
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic check_status(input string tag, input logic exp_done, input logic exp_err);
    #1;
    check({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
    check({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, ~exp_done});
    check({tag, "_ready"}, {63'd0, byte_ready}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {63'd0, byte_ready}, 64'd0);
    check({tag, "_we"}, {63'd0, im_we}, 64'd0);
    check({tag, "_addr"}, {56'd0, im_addr}, 64'd0);
    check({tag, "_wdata"}, {32'd0, im_wdata}, 64'd0);
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd1);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_error"}, {63'd0, error}, 64'd0);
  endtask

  // Three-word image: payload XOR = 2D ^ AA ^ 10 = 97.
  task automatic load_three(input int gap);
    int base;
    base = we_count;
    pulse_start();
    send_hdr(16'd3);
    send_word(8'd0, 32'h3C011000, gap);
    send_word(8'd1, 32'h8C220004, gap);
    send_word(8'd2, 32'h1000FFFF, gap);
    send_byte(8'h97, gap);
    check_status("three", 1'b1, 1'b0);
    idle_bus();
    @(negedge clk_CPU);
    check("three_write_count", 64'(we_count - base), 64'd3);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk_CPU);
    rst_CPU = 1'b0;

    // Two-word image; payload XOR = 2D ^ AD = 80.
    pulse_start();
    send_hdr(16'd2);
    send_word(8'd0, 32'h20080005, 0);
    send_word(8'd1, 32'hAC010000, 0);
    send_byte(8'h80, 0);
    check_status("good2", 1'b1, 1'b0);
    idle_bus();

    // Same image, wrong checksum.
    pulse_start();
    send_hdr(16'd2);
    send_word(8'd0, 32'h20080005, 0);
    send_word(8'd1, 32'hAC010000, 0);
    send_byte(8'h81, 0);
    check_status("badsum", 1'b0, 1'b1);
    idle_bus();

    // Empty image: only the checksum of nothing.
    pulse_start();
    send_hdr(16'd0);
    send_byte(8'h00, 0);
    check_status("empty", 1'b1, 1'b0);
    idle_bus();

    // 257 words exceeds a 256-word memory.
    pulse_start();
    send_hdr(16'h0101);
    check_status("oversize", 1'b0, 1'b1);
    idle_bus();

    load_three(0);
    load_three(2);

    // Restart in the middle of word 1; the byte in the start cycle must be ignored.
    pulse_start();
    send_hdr(16'd2);
    send_word(8'd0, 32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    @(negedge clk_CPU);
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    #1 check("start_cycle_ready", {63'd0, byte_ready}, 64'd0);
    @(posedge clk_CPU);
    #1 start = 1'b0;
    byte_valid = 1'b0;
    send_hdr(16'd1);
    send_word(8'd0, 32'h24020007, 0);
    send_byte(8'h21, 0);
    check_status("restart", 1'b1, 1'b0);
    idle_bus();

    // Asynchronous reset between edges during DATA, then a clean reload.
    pulse_start();
    send_hdr(16'd2);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    idle_bus();
    #2 rst_CPU = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk_CPU);
    rst_CPU = 1'b0;
    pulse_start();
    send_hdr(16'd2);
    send_word(8'd0, 32'h20080005, 0);
    send_word(8'd1, 32'hAC010000, 0);
    send_byte(8'h80, 0);
    check_status("after_rst", 1'b1, 1'b0);
    idle_bus();

    // Full-capacity image; A5 appears an even number of times and XOR of 0..255 is 0.
    begin
      int base;
      base = we_count;
      pulse_start();
      send_hdr(16'd256);
      for (int i = 0; i < 256; i++) send_word(8'(i), {8'hA5, 8'(i), 16'h0000}, 0);
      send_byte(8'h00, 0);
      check_status("full", 1'b1, 1'b0);
      idle_bus();
      @(negedge clk_CPU);
      check("full_write_count", 64'(we_count - base), 64'd256);
    end

    repeat (3) @(negedge clk_CPU);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
